// File: rtl/rvv_pkg.sv
// Shared vector-unit types and the memory-to-lane byte shuffle function, so the
// load-side shuffler and the store-side deshuffler use identical arithmetic.
package rvv_pkg;

  typedef enum logic [1:0] {
    EW8  = 2'd0,
    EW16 = 2'd1,
    EW32 = 2'd2,
    EW64 = 2'd3
  } vew_e;

  // Wide enough to index a block of up to 16 lanes x 16 bytes.
  typedef logic [8:0] bytes_cnt_t;

  // Destination byte inside a lane-ordered block for memory byte b.
  // Elements of EW bytes are dealt round-robin across lanes.
  function automatic bytes_cnt_t shuffle_idx(input bytes_cnt_t  b,
                                             input vew_e        sew,
                                             input int unsigned nr_lane,
                                             input int unsigned word_b);
    int unsigned ew;
    int unsigned e;
    int unsigned k;
    int unsigned lane;
    ew   = 32'd1 << sew;
    e    = 32'(b) / ew;
    k    = 32'(b) % ew;
    lane = e % nr_lane;
    return bytes_cnt_t'(lane * word_b + (e / nr_lane) * ew + k);
  endfunction

endpackage

// File: rtl/mask_generator_v1.sv
// Per-beat byte-valid mask: the first beat of a transfer drops its leading
// bytes, the last beat drops its trailing bytes; both may apply to one beat.
module mask_generator_v1 #(
  parameter  int unsigned WordB = 8,
  localparam int unsigned SkipW = $clog2(WordB)
) (
  input  logic             first_i,
  input  logic [SkipW-1:0] skip_first_i,
  input  logic             last_i,
  input  logic [SkipW-1:0] skip_last_i,
  output logic [WordB-1:0] mask_o
);

  always_comb begin
    mask_o = '1;
    for (int j = 0; j < int'(WordB); j++) begin
      if (first_i && (j < int'(skip_first_i)))             mask_o[j] = 1'b0;
      if (last_i && (j >= int'(WordB) - int'(skip_last_i))) mask_o[j] = 1'b0;
    end
  end

endmodule

// File: rtl/mem_shuffler_v1_xbar.sv
// Combinational scatter of one masked memory beat into its lane-ordered
// position inside a block; untouched block bytes come out as data 0, strobe 0.
module mem_shuffler_v1_xbar
  import rvv_pkg::*;
#(
  parameter  int unsigned NrLane        = 4,
  parameter  int unsigned VRFWordWidthB = 8,
  localparam int unsigned ByteBlock     = NrLane * VRFWordWidthB,
  localparam int unsigned SelW          = (NrLane > 1) ? $clog2(NrLane) : 1
) (
  input  logic [VRFWordWidthB*8-1:0] beat_data_i,
  input  logic [VRFWordWidthB-1:0]   beat_strb_i,
  input  logic [SelW-1:0]            sel_i,
  input  vew_e                       sew_i,
  output logic [ByteBlock*8-1:0]     blk_data_o,
  output logic [ByteBlock-1:0]       blk_strb_o
);

  // Every (sew, sel, byte) destination is an elaboration-time constant, so
  // this unrolls into a plain mux per block byte.
  always_comb begin
    int unsigned dst;
    // NOTE: every combinational output gets a default before any condition, so no latch is inferred.
    dst        = 0;
    blk_data_o = '0;
    blk_strb_o = '0;
    for (int s = 0; s < 4; s++) begin
      for (int sl = 0; sl < int'(NrLane); sl++) begin
        for (int j = 0; j < int'(VRFWordWidthB); j++) begin
          if (sew_i == vew_e'(s[1:0]) && int'(sel_i) == sl) begin
            dst = 32'(shuffle_idx(bytes_cnt_t'(sl * int'(VRFWordWidthB) + j),
                                  vew_e'(s[1:0]), NrLane, VRFWordWidthB));
            if (dst < ByteBlock) begin
              blk_data_o[dst*8 +: 8] = beat_data_i[j*8 +: 8];
              blk_strb_o[dst]        = beat_strb_i[j];
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/mem_shuffler_v1.sv
// Load-path shuffler: merges memory beats into a lane-ordered block, with a
// one-block staging buffer behind a registered output under valid/ready.
module mem_shuffler_v1
  import rvv_pkg::*;
#(
  parameter  int unsigned NrLane        = 4,
  parameter  int unsigned VRFWordWidthB = 8,
  localparam int unsigned ByteBlock     = NrLane * VRFWordWidthB,
  localparam int unsigned SelW          = (NrLane > 1) ? $clog2(NrLane) : 1,
  localparam int unsigned SkipW         = $clog2(VRFWordWidthB)
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic                                         flush_i,
  input  logic                                         in_valid_i,
  output logic                                         in_ready_o,
  input  logic [VRFWordWidthB*8-1:0]                   in_data_i,
  input  logic [SelW-1:0]                              in_sel_i,
  input  logic                                         in_first_i,
  input  logic [SkipW-1:0]                             in_skip_first_i,
  input  logic                                         in_last_i,
  input  logic [SkipW-1:0]                             in_skip_last_i,
  input  vew_e                                         in_sew_i,
  output logic                                         out_valid_o,
  input  logic                                         out_ready_i,
  output logic [NrLane-1:0][VRFWordWidthB*8-1:0]       out_data_o,
  output logic [NrLane-1:0][VRFWordWidthB-1:0]         out_strb_o,
  output logic                                         out_last_o
);

  logic                      open_q, open_d;
  logic                      stg_full_q, stg_full_d;
  logic                      stg_last_q, stg_last_d;
  vew_e                      sew_q, sew_d;
  logic [SelW-1:0]           last_sel_q, last_sel_d;
  logic [ByteBlock*8-1:0]    acc_data_q, acc_data_d;
  logic [ByteBlock-1:0]      acc_strb_q, acc_strb_d;
  logic                      out_valid_q, out_valid_d;
  logic                      out_last_q, out_last_d;
  logic [ByteBlock*8-1:0]    out_data_q, out_data_d;
  logic [ByteBlock-1:0]      out_strb_q, out_strb_d;

  logic [VRFWordWidthB-1:0]   beat_mask;
  logic [VRFWordWidthB*8-1:0] beat_data;
  logic [ByteBlock*8-1:0]     shuf_data;
  logic [ByteBlock-1:0]       shuf_strb;
  vew_e                       sew_eff;
  logic                       beat_fire, out_free, closing;

  mask_generator_v1 #(.WordB(VRFWordWidthB)) u_mask (
    .first_i      (in_first_i),
    .skip_first_i (in_skip_first_i),
    .last_i       (in_last_i),
    .skip_last_i  (in_skip_last_i),
    .mask_o       (beat_mask)
  );

  mem_shuffler_v1_xbar #(.NrLane(NrLane), .VRFWordWidthB(VRFWordWidthB)) u_xbar (
    .beat_data_i (beat_data),
    .beat_strb_i (beat_mask),
    .sel_i       (in_sel_i),
    .sew_i       (sew_eff),
    .blk_data_o  (shuf_data),
    .blk_strb_o  (shuf_strb)
  );

  always_comb begin
    for (int j = 0; j < int'(VRFWordWidthB); j++) begin
      beat_data[j*8 +: 8] = beat_mask[j] ? in_data_i[j*8 +: 8] : 8'h00;
    end
  end

  // Element width is fixed by the first beat of a block.
  assign sew_eff   = open_q ? sew_q : in_sew_i;
  assign beat_fire = in_valid_i && !stg_full_q;
  assign out_free  = !out_valid_q || out_ready_i;
  assign closing   = (32'(in_sel_i) == NrLane - 1) || in_last_i;

  always_comb begin
    open_d      = open_q;
    stg_full_d  = stg_full_q;
    stg_last_d  = stg_last_q;
    sew_d       = sew_q;
    last_sel_d  = last_sel_q;
    acc_data_d  = acc_data_q;
    acc_strb_d  = acc_strb_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    out_strb_d  = out_strb_q;

    if (out_valid_q && out_ready_i) out_valid_d = 1'b0;

    if (stg_full_q && out_free) begin
      out_valid_d = 1'b1;
      out_last_d  = stg_last_q;
      out_data_d  = acc_data_q;
      out_strb_d  = acc_strb_q;
      stg_full_d  = 1'b0;
      stg_last_d  = 1'b0;
      acc_data_d  = '0;
      acc_strb_d  = '0;
    end else if (beat_fire) begin
      if (!open_q) sew_d = in_sew_i;
      last_sel_d = in_sel_i;
      if (!closing) begin
        open_d     = 1'b1;
        acc_data_d = acc_data_q | shuf_data;
        acc_strb_d = acc_strb_q | shuf_strb;
      end else if (out_free) begin
        open_d      = 1'b0;
        out_valid_d = 1'b1;
        out_last_d  = in_last_i;
        out_data_d  = acc_data_q | shuf_data;
        out_strb_d  = acc_strb_q | shuf_strb;
        acc_data_d  = '0;
        acc_strb_d  = '0;
      end else begin
        // Output still held: the finished block waits in the accumulator.
        open_d     = 1'b0;
        stg_full_d = 1'b1;
        stg_last_d = in_last_i;
        acc_data_d = acc_data_q | shuf_data;
        acc_strb_d = acc_strb_q | shuf_strb;
      end
    end

    if (flush_i) begin
      open_d      = 1'b0;
      stg_full_d  = 1'b0;
      stg_last_d  = 1'b0;
      sew_d       = EW8;
      last_sel_d  = '0;
      acc_data_d  = '0;
      acc_strb_d  = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_data_d  = '0;
      out_strb_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      open_q      <= 1'b0;
      stg_full_q  <= 1'b0;
      stg_last_q  <= 1'b0;
      sew_q       <= EW8;
      last_sel_q  <= '0;
      acc_data_q  <= '0;
      acc_strb_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
      open_q      <= open_d;
      stg_full_q  <= stg_full_d;
      stg_last_q  <= stg_last_d;
      sew_q       <= sew_d;
      last_sel_q  <= last_sel_d;
      acc_data_q  <= acc_data_d;
      acc_strb_q  <= acc_strb_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_strb_q  <= out_strb_d;
    end
  end

  assign in_ready_o  = !stg_full_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign out_data_o  = out_data_q;
  assign out_strb_o  = out_strb_q;

`ifndef SYNTHESIS
  a_sew_stable: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
    (beat_fire && open_q) |-> (in_sew_i == sew_q))
    else $error("element width changed inside an open block");
  a_sel_incr: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
    (beat_fire && open_q) |-> (in_sel_i > last_sel_q))
    else $error("beat slot not increasing inside a block");
  a_sel_range: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
    beat_fire |-> (32'(in_sel_i) < NrLane))
    else $error("beat slot out of range");
`endif

endmodule
